// File: rtl/matmul_pkg.sv
// Shared types and derived constants for the matrix-multiply sequencer.
// Sizes below are for the default 4-bit, 3x3 configuration; the functions handle other sizes.
package matmul_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_A    = 3'd1,
    S_LOAD_B    = 3'd2,
    S_COMPUTE   = 3'd3,
    S_STORE     = 3'd4,
    S_SEND      = 3'd5,
    S_SEND_WAIT = 3'd6
  } state_t;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_N          = 3;
  localparam logic [7:0] SAT_LIMIT = 8'hFF;

  // Two nibble-packed elements per byte, rounded up.
  function automatic int calc_nb(input int n);
    return (n * n + 1) / 2;
  endfunction

  // Wide enough to sum n full-scale products without wrapping.
  function automatic int calc_acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  localparam int NN    = DEF_N * DEF_N;
  localparam int NB    = calc_nb(DEF_N);
  localparam int ACC_W = calc_acc_w(DEF_DATA_WIDTH, DEF_N);

endpackage

// File: rtl/matmul_mac.sv
// Single shared multiply-accumulate unit, stepped once per COMPUTE cycle.
module matmul_mac import matmul_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = ACC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + ACC_WIDTH'(a) * ACC_WIDTH'(b);
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Loads nibble-packed A/B over UART, runs the time-multiplexed MAC over all (i,j,k),
// saturates results into C and streams C back with a start/busy handshake.
module matmul_seq_ctrl import matmul_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int OUT_WIDTH  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic       rx_overrun,
  output logic [2:0] state
);

  localparam int NUM_EL    = N * N;
  localparam int NUM_BYTES = calc_nb(N);
  localparam int ACC_BITS  = calc_acc_w(DATA_WIDTH, N);
  localparam int AW        = $clog2(NUM_EL);
  localparam int CW        = $clog2(NUM_EL + 1);
  localparam logic [CW-1:0] N_LAST    = CW'(N - 1);
  localparam logic [CW-1:0] EL_LAST   = CW'(NUM_EL - 1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(NUM_BYTES - 1);

  state_t st, st_n;
  logic [CW-1:0] bcnt, bcnt_n, i, i_n, j, j_n, k, k_n, idx, idx_n;
  logic slack, slack_n;
  logic [7:0] tx_data_n;
  logic tx_start_n, done_n, ovf_n, ovr_n;
  logic a_we, b_we, c_we, mac_en, mac_clr;
  logic [DATA_WIDTH-1:0] a_mem [NUM_EL];
  logic [DATA_WIDTH-1:0] b_mem [NUM_EL];
  logic [OUT_WIDTH-1:0]  c_mem [NUM_EL];
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [DATA_WIDTH-1:0] nib_lo, nib_hi;
  logic [ACC_BITS-1:0] acc;

  function automatic logic sat_hit(input logic [ACC_BITS-1:0] v);
    return v > ACC_BITS'(SAT_LIMIT);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] sat_out(input logic [ACC_BITS-1:0] v);
    if (sat_hit(v)) return SAT_LIMIT;
    return v[OUT_WIDTH-1:0];
  endfunction

  assign a_addr = AW'(i * N + k);
  assign b_addr = AW'(k * N + j);
  assign c_addr = AW'(i * N + j);
  assign nib_lo = DATA_WIDTH'(rx_data[3:0]);
  assign nib_hi = DATA_WIDTH'(rx_data[7:4]);
  assign busy   = (st != S_IDLE);
  assign state  = st;

  matmul_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_BITS)) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (a_mem[a_addr]),
    .b   (b_mem[b_addr]),
    .acc (acc)
  );

  // Byte bcnt carries elements 2*bcnt (low nibble) and 2*bcnt+1 (high nibble).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < NUM_EL; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
        c_mem[e] <= '0;
      end
    end else begin
      for (int e = 0; e < NUM_EL; e++) begin
        if (e / 2 == int'(bcnt)) begin
          if (a_we) a_mem[e] <= (e % 2 == 1) ? nib_hi : nib_lo;
          if (b_we) b_mem[e] <= (e % 2 == 1) ? nib_hi : nib_lo;
        end
      end
      if (c_we) c_mem[c_addr] <= sat_out(acc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= S_IDLE;
      bcnt <= '0; i <= '0; j <= '0; k <= '0; idx <= '0;
      slack <= 1'b0;
      tx_data <= '0; tx_start <= 1'b0; done <= 1'b0;
      ovf <= 1'b0; rx_overrun <= 1'b0;
    end else begin
      st <= st_n;
      bcnt <= bcnt_n; i <= i_n; j <= j_n; k <= k_n; idx <= idx_n;
      slack <= slack_n;
      tx_data <= tx_data_n; tx_start <= tx_start_n; done <= done_n;
      ovf <= ovf_n; rx_overrun <= ovr_n;
    end
  end

  always_comb begin
    st_n = st;
    bcnt_n = bcnt; i_n = i; j_n = j; k_n = k; idx_n = idx;
    slack_n = slack;
    tx_data_n = tx_data; tx_start_n = 1'b0; done_n = 1'b0;
    ovf_n = ovf; ovr_n = rx_overrun;
    a_we = 1'b0; b_we = 1'b0; c_we = 1'b0; mac_en = 1'b0; mac_clr = 1'b0;
    if (abort) begin
      st_n = S_IDLE;
      bcnt_n = '0; i_n = '0; j_n = '0; k_n = '0; idx_n = '0;
      slack_n = 1'b0;
      mac_clr = 1'b1;
    end else begin
      if (rx_ready && (st inside {S_COMPUTE, S_STORE, S_SEND, S_SEND_WAIT})) ovr_n = 1'b1;
      case (st)
        S_IDLE: if (rx_ready) begin
          a_we = 1'b1;
          bcnt_n = CW'(1);
          ovf_n = 1'b0;
          ovr_n = 1'b0;
          st_n = S_LOAD_A;
        end
        S_LOAD_A, S_LOAD_B: if (rx_ready) begin
          a_we = (st == S_LOAD_A);
          b_we = (st == S_LOAD_B);
          if (bcnt == BYTE_LAST) begin
            bcnt_n = '0;
            if (st == S_LOAD_A) begin
              st_n = S_LOAD_B;
            end else begin
              st_n = S_COMPUTE;
              i_n = '0; j_n = '0; k_n = '0;
              mac_clr = 1'b1;
            end
          end else begin
            bcnt_n = bcnt + CW'(1);
          end
        end
        S_COMPUTE: begin
          mac_en = 1'b1;
          if (k == N_LAST) begin
            k_n = '0;
            st_n = S_STORE;
          end else begin
            k_n = k + CW'(1);
          end
        end
        S_STORE: begin
          c_we = 1'b1;
          mac_clr = 1'b1;
          if (sat_hit(acc)) ovf_n = 1'b1;
          st_n = S_COMPUTE;
          if (j == N_LAST) begin
            j_n = '0;
            if (i == N_LAST) begin
              i_n = '0;
              idx_n = '0;
              st_n = S_SEND;
            end else begin
              i_n = i + CW'(1);
            end
          end else begin
            j_n = j + CW'(1);
          end
        end
        S_SEND: if (!tx_busy) begin
          tx_data_n = c_mem[AW'(idx)];
          tx_start_n = 1'b1;
          st_n = S_SEND_WAIT;
        end
        // tx_busy is not trusted during the start cycle or the one after it.
        S_SEND_WAIT: begin
          if (tx_start) begin
            slack_n = 1'b1;
          end else if (slack) begin
            slack_n = 1'b0;
          end else if (!tx_busy) begin
            if (idx == EL_LAST) begin
              done_n = 1'b1;
              idx_n = '0;
              st_n = S_IDLE;
            end else begin
              idx_n = idx + CW'(1);
              st_n = S_SEND;
            end
          end
        end
        default: st_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: table vectors, corner-case sequences and random frames
// checked against a plain matrix-multiply reference.
module tb_matmul_seq_ctrl;
  import matmul_pkg::*;

  typedef logic [2*NB-1:0][7:0] frame_t;
  typedef logic [NN-1:0][7:0]   cvec_t;
  typedef struct packed {
    frame_t      frame;
    cvec_t       exp_c;
    logic        exp_ovf;
    logic [31:0] hold;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ready = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start, busy, done, ovf, rx_overrun;
  logic [2:0] state;

  int n_chk = 0;
  int n_err = 0;

  int n_start = 0, n_done = 0, comp_cyc = 0, dbl_start = 0, busy_left = 0, tx_hold = 0;
  logic prev_start = 1'b0;
  logic [7:0] tx_q [$];

  vec_t vecs [3];

  always #5 clk = ~clk;

  matmul_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .rx_overrun (rx_overrun),
    .state      (state)
  );

  // Transmitter model and event counters, all sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      busy_left = 0;
    end else if (tx_start) begin
      tx_q.push_back(tx_data);
      n_start++;
      if (prev_start) dbl_start++;
      busy_left = tx_hold;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    prev_start = tx_start;
    tx_busy = (busy_left > 0);
    if (done) n_done++;
    if (state == S_COMPUTE || state == S_STORE) comp_cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, n_done=%0d required progress", n_done);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input frame_t f, output cvec_t c, output logic ov);
    int a [NN];
    int b [NN];
    int s;
    ov = 1'b0;
    for (int m = 0; m < NN; m++) begin
      a[m] = (m % 2 == 1) ? int'(f[m/2][7:4]) : int'(f[m/2][3:0]);
      b[m] = (m % 2 == 1) ? int'(f[NB + m/2][7:4]) : int'(f[NB + m/2][3:0]);
    end
    for (int r = 0; r < DEF_N; r++)
      for (int col = 0; col < DEF_N; col++) begin
        s = 0;
        for (int t = 0; t < DEF_N; t++) s += a[r*DEF_N + t] * b[t*DEF_N + col];
        if (s > 255) begin
          c[r*DEF_N + col] = 8'hFF;
          ov = 1'b1;
        end else begin
          c[r*DEF_N + col] = 8'(s);
        end
      end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic load_frame(input frame_t f);
    for (int n = 0; n < 2*NB; n++) send_byte(f[n]);
  endtask

  task automatic run_frame(input string nm, input frame_t f, input cvec_t ec, input logic eov,
                           input int hold, input bit inject, input logic eovr);
    int base, d0, s0, c0, w;
    tx_hold = hold;
    base = tx_q.size();
    d0 = n_done;
    s0 = n_start;
    c0 = comp_cyc;
    load_frame(f);
    if (inject) begin
      repeat (4) @(posedge clk);
      send_byte(8'h55);
      @(negedge clk);
      chk({nm, "_in_compute"}, 32'(state == S_COMPUTE || state == S_STORE), 1);
      chk({nm, "_ovr_now"}, 32'(rx_overrun), 1);
    end
    w = 0;
    while (n_done == d0 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk({nm, "_done_pulses"}, n_done - d0, 1);
    chk({nm, "_tx_starts"}, n_start - s0, NN);
    chk({nm, "_tx_bytes"}, tx_q.size() - base, NN);
    for (int b = 0; b < NN; b++)
      if (base + b < tx_q.size())
        chk($sformatf("%s_c%0d", nm, b), 32'(tx_q[base + b]), 32'(ec[b]));
    chk({nm, "_ovf"}, 32'(ovf), 32'(eov));
    chk({nm, "_rx_overrun"}, 32'(rx_overrun), 32'(eovr));
    chk({nm, "_compute_cycles"}, comp_cyc - c0, 36);
    chk({nm, "_idle"}, 32'(state), 32'(S_IDLE));
    chk({nm, "_tx_data_held"}, 32'(tx_data), 32'(ec[NN-1]));
  endtask

  initial begin
    int w;
    vecs[0].frame = {8'h09, 8'h87, 8'h65, 8'h43, 8'h21, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
    vecs[0].exp_c = {8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    vecs[0].exp_ovf = 1'b0;
    vecs[0].hold = 0;
    vecs[1].frame = '1;
    vecs[1].exp_c = '1;
    vecs[1].exp_ovf = 1'b1;
    vecs[1].hold = 2;
    vecs[2].frame = {8'h09, 8'h87, 8'h65, 8'h43, 8'h21, 8'h01, 8'h11, 8'h11, 8'h11, 8'h11};
    vecs[2].exp_c = {8'h12, 8'h0F, 8'h0C, 8'h12, 8'h0F, 8'h0C, 8'h12, 8'h0F, 8'h0C};
    vecs[2].exp_ovf = 1'b0;
    vecs[2].hold = 100;

    repeat (3) @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_rx_overrun", 32'(rx_overrun), 0);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    rst = 1'b0;

    for (int v = 0; v < 3; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].frame, vecs[v].exp_c, vecs[v].exp_ovf,
                int'(vecs[v].hold), 1'b0, 1'b0);

    run_frame("overrun", vecs[0].frame, vecs[0].exp_c, 1'b0, 0, 1'b1, 1'b1);

    for (int n = 0; n < 3; n++) send_byte(8'hFF);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_load_state", 32'(state), 32'(S_IDLE));
    chk("abort_load_busy", 32'(busy), 0);
    run_frame("after_abort", vecs[0].frame, vecs[0].exp_c, 1'b0, 0, 1'b0, 1'b0);

    run_frame("sat_again", vecs[1].frame, vecs[1].exp_c, 1'b1, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rx_data = 8'h5A;
    rx_ready = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_rx_state", 32'(state), 32'(S_IDLE));
    chk("abort_rx_ovf_held", 32'(ovf), 1);
    run_frame("after_abort_rx", vecs[0].frame, vecs[0].exp_c, 1'b0, 0, 1'b0, 1'b0);

    tx_hold = 100;
    load_frame(vecs[1].frame);
    w = 0;
    while (state != S_SEND_WAIT && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("rstsend_reached_wait", 32'(state), 32'(S_SEND_WAIT));
    chk("rstsend_ovf_before", 32'(ovf), 1);
    #2 rst = 1'b1;
    #1;
    chk("rstsend_tx_data", 32'(tx_data), 0);
    chk("rstsend_tx_start", 32'(tx_start), 0);
    chk("rstsend_busy", 32'(busy), 0);
    chk("rstsend_done", 32'(done), 0);
    chk("rstsend_ovf", 32'(ovf), 0);
    chk("rstsend_rx_overrun", 32'(rx_overrun), 0);
    chk("rstsend_state", 32'(state), 32'(S_IDLE));
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    run_frame("after_rst", vecs[0].frame, vecs[0].exp_c, 1'b0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 5; r++) begin
      frame_t f;
      cvec_t ec;
      logic eo;
      for (int n = 0; n < 2*NB; n++) begin
        f[n] = 8'($urandom);
        if (r % 2 == 1) f[n] = f[n] & 8'h33;
      end
      model(f, ec, eo);
      run_frame($sformatf("rand%0d", r), f, ec, eo, int'($urandom_range(0, 4)), 1'b0, 1'b0);
    end

    chk("no_back_to_back_start", dbl_start, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
